khoi_tinh_toan_tuantu: RTL and testbench

//  Parametrised multi-cycle ALU: add, subtract, multiply, divide on W-bit operands.

---
 rtl/khoi_tinh_toan_tuantu.sv | 179 +++++++++++++++++
 tb/tb_khoi_tinh_toan_tuantu.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/khoi_tinh_toan_tuantu.sv
// Multi-cycle W-bit ALU: add/sub in one step, shift-add multiply, restoring divide.
// Define DIV0_ERR_EN to short-circuit divide-by-zero and report it on err.
module khoi_tinh_toan_tuantu #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] g,
    output logic [W-1:0] du,
    output logic         ovf
`ifdef DIV0_ERR_EN
    ,
    output logic         err
`endif
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDSUB = 3'd1,
        MUL    = 3'd2,
        DIV    = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t         state;
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;
    logic [1:0]     rop;
    logic           rcin;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] acc;

    logic [W:0]     add_res;
    logic [W:0]     sub_res;
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    logic [W:0]     div_sh;
    logic [W:0]     div_diff;
    logic [2*W-1:0] div_next;
    logic           div0;

    assign add_res = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rcin};
    assign sub_res = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rcin};

    // acc = {partial high half, remaining multiplier bits}
    assign mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, ra} : {(W+1){1'b0}});
    assign mul_next = {mul_sum, acc[W-1:1]};

    // acc = {partial remainder, dividend bits still to consume / quotient bits}
    assign div_sh   = acc[2*W-1:W-1];
    assign div_diff = div_sh - {1'b0, rb};
    assign div_next = div_diff[W] ? {div_sh[W-1:0], acc[W-2:0], 1'b0}
                                  : {div_diff[W-1:0], acc[W-2:0], 1'b1};

`ifdef DIV0_ERR_EN
    assign div0 = (b == '0);
`else
    assign div0 = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            g     <= '0;
            du    <= '0;
            ovf   <= 1'b0;
            ra    <= '0;
            rb    <= '0;
            rop   <= 2'b00;
            rcin  <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
`ifdef DIV0_ERR_EN
            err   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        ra   <= a;
                        rb   <= b;
                        rop  <= op;
                        rcin <= cin;
                        cnt  <= CW'(W);
                        busy <= 1'b1;
                        unique case (op)
                            2'b10: begin
                                acc   <= {{W{1'b0}}, b};
                                state <= MUL;
                            end
                            2'b11: begin
                                acc   <= {{W{1'b0}}, a};
                                state <= div0 ? ADDSUB : DIV;
                            end
                            default: begin
                                acc   <= '0;
                                state <= ADDSUB;
                            end
                        endcase
                    end else begin
                        state <= IDLE;
                    end
                end
                ADDSUB: begin
                    unique case (rop)
                        2'b00: begin
                            g   <= add_res[W-1:0];
                            ovf <= add_res[W];
                        end
                        2'b01: begin
                            g   <= sub_res[W-1:0];
                            ovf <= sub_res[W];
                        end
                        default: begin
                            g   <= '0;
                            ovf <= 1'b0;
                        end
                    endcase
                    du    <= '0;
`ifdef DIV0_ERR_EN
                    err   <= (rop == 2'b11);
`endif
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                MUL: begin
                    if (cnt == '0) begin
                        g     <= acc[W-1:0];
                        du    <= '0;
                        ovf   <= |acc[2*W-1:W];
`ifdef DIV0_ERR_EN
                        err   <= 1'b0;
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        acc <= mul_next;
                        cnt <= cnt - 1'b1;
                    end
                end
                DIV: begin
                    if (cnt == '0) begin
                        g     <= acc[W-1:0];
                        du    <= acc[2*W-1:W];
                        ovf   <= 1'b0;
`ifdef DIV0_ERR_EN
                        err   <= 1'b0;
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        acc <= div_next;
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_khoi_tinh_toan_tuantu.sv
// Directed self-checking bench for khoi_tinh_toan_tuantu at W=8.
// Expectations for divide-by-zero follow DIV0_ERR_EN when defined.
module tb_khoi_tinh_toan_tuantu;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] g;
    logic [7:0] du;
    logic       ovf;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    khoi_tinh_toan_tuantu #(.W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .g     (g),
        .du    (du),
        .ovf   (ovf)
`ifdef DIV0_ERR_EN
        ,
        .err   (err)
`endif
    );

`ifndef DIV0_ERR_EN
    assign err = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op, scramble inputs after accept, count edges to done.
    task automatic run_op(input logic [1:0] o, input logic [7:0] x,
                          input logic [7:0] y, input logic c,
                          output int lat, output logic busy_after_t);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        cin   = c;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 2'($urandom);
        a     = 8'($urandom);
        b     = 8'($urandom);
        cin   = 1'($urandom);
        busy_after_t = busy;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = 8'd0;
        b     = 8'd0;
        cin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_checks++;
        if ({busy, done, g, du, ovf, err} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_state got %h exp 0",
                     {busy, done, g, du, ovf, err});
        end
    endtask

    task automatic test_add();
        int   lat;
        logic bt;
        run_op(2'b00, 8'd200, 8'd100, 1'b1, lat, bt);
        n_checks++;
        if (lat !== 1) begin
            n_fail++;
            $display("FAIL add_latency got %0d exp 1", lat);
        end
        n_checks++;
        if ({bt, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL add_busy got %b exp 10", {bt, busy});
        end
        n_checks++;
        if ({g, du, ovf, err} !== {8'd45, 8'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL add_result got g=%0d du=%0d ovf=%b err=%b exp 45 0 1 0",
                     g, du, ovf, err);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({done, g, ovf} !== {1'b0, 8'd45, 1'b1}) begin
            n_fail++;
            $display("FAIL add_hold got done=%b g=%0d ovf=%b exp 0 45 1",
                     done, g, ovf);
        end
    endtask

    task automatic test_sub();
        int   lat;
        logic bt;
        run_op(2'b01, 8'd5, 8'd7, 1'b0, lat, bt);
        n_checks++;
        if ({lat == 1, g, du, ovf} !== {1'b1, 8'd254, 8'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL sub_borrow got lat=%0d g=%0d du=%0d ovf=%b exp 1 254 0 1",
                     lat, g, du, ovf);
        end
        run_op(2'b01, 8'd9, 8'd3, 1'b1, lat, bt);
        n_checks++;
        if ({lat == 1, g, du, ovf} !== {1'b1, 8'd5, 8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_noborrow got lat=%0d g=%0d du=%0d ovf=%b exp 1 5 0 0",
                     lat, g, du, ovf);
        end
    endtask

    task automatic test_mul();
        int   lat;
        logic bt;
        run_op(2'b10, 8'd16, 8'd17, 1'b1, lat, bt);
        n_checks++;
        if (lat !== 9) begin
            n_fail++;
            $display("FAIL mul_latency got %0d exp 9", lat);
        end
        n_checks++;
        if ({g, du, ovf, err} !== {8'd16, 8'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL mul_ovf got g=%0d du=%0d ovf=%b err=%b exp 16 0 1 0",
                     g, du, ovf, err);
        end
        run_op(2'b10, 8'd15, 8'd17, 1'b0, lat, bt);
        n_checks++;
        if ({lat == 9, g, du, ovf} !== {1'b1, 8'd255, 8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL mul_fit got lat=%0d g=%0d du=%0d ovf=%b exp 9 255 0 0",
                     lat, g, du, ovf);
        end
    endtask

    task automatic test_back_to_back();
        int   lat;
        logic bt;
        run_op(2'b11, 8'd200, 8'd7, 1'b0, lat, bt);
        n_checks++;
        if (lat !== 9) begin
            n_fail++;
            $display("FAIL div_latency got %0d exp 9", lat);
        end
        n_checks++;
        if ({g, du, ovf, err} !== {8'd28, 8'd4, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL div_result got g=%0d du=%0d ovf=%b err=%b exp 28 4 0 0",
                     g, du, ovf, err);
        end
        run_op(2'b00, 8'd1, 8'd2, 1'b0, lat, bt);
        n_checks++;
        if ({bt, lat == 1, g, du, ovf} !== {2'b11, 8'd3, 8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_accept got busy=%b lat=%0d g=%0d du=%0d ovf=%b exp 1 1 3 0 0",
                     bt, lat, g, du, ovf);
        end
    endtask

    task automatic test_div0();
        int   lat;
        logic bt;
        run_op(2'b11, 8'd77, 8'd0, 1'b0, lat, bt);
`ifdef DIV0_ERR_EN
        n_checks++;
        if ({lat == 1, g, du, ovf, err} !== {1'b1, 8'd0, 8'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL div0_err got lat=%0d g=%0d du=%0d ovf=%b err=%b exp 1 0 0 0 1",
                     lat, g, du, ovf, err);
        end
        run_op(2'b00, 8'd1, 8'd1, 1'b0, lat, bt);
        n_checks++;
        if ({g, err} !== {8'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL err_clear got g=%0d err=%b exp 2 0", g, err);
        end
`else
        n_checks++;
        if ({lat == 9, g, du, ovf} !== {1'b1, 8'd255, 8'd77, 1'b0}) begin
            n_fail++;
            $display("FAIL div0_plain got lat=%0d g=%0d du=%0d ovf=%b exp 9 255 77 0",
                     lat, g, du, ovf);
        end
`endif
    endtask

    task automatic test_abort();
        int seen_done = 0;
        start = 1'b1;
        op    = 2'b10;
        a     = 8'd16;
        b     = 8'd17;
        cin   = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        op    = 2'b00;
        a     = 8'd1;
        b     = 8'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_checks++;
        if ({busy, done} !== 2'b10) begin
            n_fail++;
            $display("FAIL busy_ignore got busy=%b done=%b exp 1 0", busy, done);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_checks++;
        if ({busy, done, g, du, ovf, err} !== 19'd0) begin
            n_fail++;
            $display("FAIL abort_reset got %h exp 0",
                     {busy, done, g, du, ovf, err});
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
        end
        n_checks++;
        if (seen_done !== 0) begin
            n_fail++;
            $display("FAIL abort_nodone got %0d pulses exp 0", seen_done);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_back_to_back();
        test_div0();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
